fc_seq_ctrl: RTL and testbench

Sequencer for the fully-connected layer datapath: on a start pulse it walks the output neurons in tiles of ARRAY_N and streams the input vector and weight words into the FC array. It clears and enables the accumulators, drains the pipeline, and writes each tile's results to output memory. It then raises a held done level that also gates the FC clock counter (start/done pair).

---
 rtl/fc_seq_ctrl.sv | 129 ++++++++++++
 tb/tb_fc_seq_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_seq_ctrl.sv
// fc_seq_ctrl: tiled FC-layer sequencer (clear, feed, drain, write per tile); FC_SEQ_CYCLE_CNT_EN adds a busy-cycle counter
module fc_seq_ctrl #(
  parameter int IN_DIM = 256,
  parameter int OUT_DIM = 64,
  parameter int ARRAY_N = 8,
  parameter int PIPE_LAT = 3,
  localparam int TILES = OUT_DIM / ARRAY_N,
  localparam int IW = IN_DIM > 1 ? $clog2(IN_DIM) : 1,
  localparam int WW = IN_DIM * TILES > 1 ? $clog2(IN_DIM * TILES) : 1,
  localparam int NW = ARRAY_N > 1 ? $clog2(ARRAY_N) : 1,
  localparam int OW = OUT_DIM > 1 ? $clog2(OUT_DIM) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          in_rd_en,
  output logic [IW-1:0] in_rd_addr,
  output logic          w_rd_en,
  output logic [WW-1:0] w_rd_addr,
  output logic          acc_clr,
  output logic          acc_en,
  output logic [NW-1:0] out_sel,
  output logic          out_wr_en,
  output logic [OW-1:0] out_wr_addr,
  output logic [31:0]   cycle_count
);
  localparam int TW = TILES > 1 ? $clog2(TILES) : 1;
  localparam int DW = PIPE_LAT > 1 ? $clog2(PIPE_LAT) : 1;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, WRITE, DONE} state_t;
  state_t state;
  logic [TW-1:0] tile;
  logic [DW-1:0] drain;
  logic [WW-1:0] w_next;
  logic [OW-1:0] o_next;
  // w_next/o_next walk tile*IN_DIM+k and tile*ARRAY_N+j without multipliers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      tile <= '0;
      drain <= '0;
      w_next <= '0;
      o_next <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      in_rd_en <= 1'b0;
      in_rd_addr <= '0;
      w_rd_en <= 1'b0;
      w_rd_addr <= '0;
      acc_clr <= 1'b0;
      acc_en <= 1'b0;
      out_sel <= '0;
      out_wr_en <= 1'b0;
      out_wr_addr <= '0;
    end else begin
      acc_en <= in_rd_en;
      acc_clr <= 1'b0;
      case (state)
        IDLE, DONE:
          if (start) begin
            state <= CLEAR;
            acc_clr <= 1'b1;
            busy <= 1'b1;
            done <= 1'b0;
            tile <= '0;
            w_next <= '0;
            o_next <= '0;
          end
        CLEAR: begin
          state <= FEED;
          in_rd_en <= 1'b1;
          w_rd_en <= 1'b1;
          in_rd_addr <= '0;
          w_rd_addr <= w_next;
          w_next <= w_next + 1'b1;
        end
        FEED:
          if (in_rd_addr == IW'(IN_DIM - 1)) begin
            state <= DRAIN;
            in_rd_en <= 1'b0;
            w_rd_en <= 1'b0;
            drain <= '0;
          end else begin
            in_rd_addr <= in_rd_addr + 1'b1;
            w_rd_addr <= w_next;
            w_next <= w_next + 1'b1;
          end
        DRAIN:
          if (drain == DW'(PIPE_LAT - 1)) begin
            state <= WRITE;
            out_wr_en <= 1'b1;
            out_sel <= '0;
            out_wr_addr <= o_next;
            o_next <= o_next + 1'b1;
          end else begin
            drain <= drain + 1'b1;
          end
        WRITE:
          if (out_sel == NW'(ARRAY_N - 1)) begin
            out_wr_en <= 1'b0;
            if (tile == TW'(TILES - 1)) begin
              state <= DONE;
              busy <= 1'b0;
              done <= 1'b1;
            end else begin
              state <= CLEAR;
              acc_clr <= 1'b1;
              tile <= tile + 1'b1;
            end
          end else begin
            out_sel <= out_sel + 1'b1;
            out_wr_addr <= o_next;
            o_next <= o_next + 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
`ifdef FC_SEQ_CYCLE_CNT_EN
  logic [31:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (start && (state == IDLE || state == DONE)) cnt <= '0;
    else if (busy && cnt != 32'hFFFF_FFFF) cnt <= cnt + 1'b1;
  assign cycle_count = cnt;
`else
  assign cycle_count = '0;
`endif
endmodule

// File: tb/tb_fc_seq_ctrl.sv
// tb_fc_seq_ctrl: scoreboard bench for fc_seq_ctrl at IN_DIM=4, OUT_DIM=4, ARRAY_N=2, PIPE_LAT=2
module tb_fc_seq_ctrl;
  localparam int IN_DIM = 4, OUT_DIM = 4, ARRAY_N = 2, PIPE_LAT = 2;
  localparam int TILES = OUT_DIM / ARRAY_N;
  localparam int RUN = TILES * (1 + IN_DIM + PIPE_LAT + ARRAY_N);
`ifdef FC_SEQ_CYCLE_CNT_EN
  localparam logic [31:0] EXP_CC = 32'(RUN);
`else
  localparam logic [31:0] EXP_CC = 32'd0;
`endif
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic busy, done, in_rd_en, w_rd_en, acc_clr, acc_en, out_wr_en;
  logic [1:0] in_rd_addr, out_wr_addr;
  logic [2:0] w_rd_addr;
  logic [0:0] out_sel;
  logic [31:0] cycle_count;
  logic [46:0] all_out;
  int checks = 0, errors = 0;
  int busy_cnt = 0, clr_cnt = 0, en_cnt = 0;
  int ma, mb, n;
  logic prev_in = 1'b0;
  int exp_w[$], exp_k[$], exp_o[$], exp_j[$];

  fc_seq_ctrl #(.IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM), .ARRAY_N(ARRAY_N), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr), .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
    .acc_clr(acc_clr), .acc_en(acc_en), .out_sel(out_sel), .out_wr_en(out_wr_en),
    .out_wr_addr(out_wr_addr), .cycle_count(cycle_count)
  );

  assign all_out = {busy, done, in_rd_en, in_rd_addr, w_rd_en, w_rd_addr, acc_clr, acc_en,
                    out_sel, out_wr_en, out_wr_addr, cycle_count};

  always #5 clk = ~clk;

  // monitor: acc_en alignment every cycle, scoreboard pops on each read/write strobe
  always @(negedge clk) begin
    if (rst) prev_in = 1'b0;
    else begin
      if (busy) busy_cnt++;
      if (acc_clr) clr_cnt++;
      if (acc_en) en_cnt++;
      checks++;
      if (acc_en !== prev_in) begin
        errors++;
        $display("FAIL acc_en_align t=%0t: got %b want %b", $time, acc_en, prev_in);
      end
      prev_in = in_rd_en;
      if (w_rd_en || in_rd_en) begin
        checks++;
        if (exp_w.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected t=%0t: got w_rd_addr %0d with empty queue", $time, w_rd_addr);
        end else begin
          ma = exp_w.pop_front();
          mb = exp_k.pop_front();
          if (w_rd_addr !== 3'(ma) || in_rd_addr !== 2'(mb) || w_rd_en !== in_rd_en) begin
            errors++;
            $display("FAIL rd_addr t=%0t: got w %0d k %0d en %b%b want w %0d k %0d en 11",
                     $time, w_rd_addr, in_rd_addr, w_rd_en, in_rd_en, ma, mb);
          end
        end
      end
      if (out_wr_en) begin
        checks++;
        if (exp_o.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected t=%0t: got out_wr_addr %0d with empty queue", $time, out_wr_addr);
        end else begin
          ma = exp_o.pop_front();
          mb = exp_j.pop_front();
          if (out_wr_addr !== 2'(ma) || out_sel !== 1'(mb)) begin
            errors++;
            $display("FAIL wr_addr t=%0t: got addr %0d sel %0d want addr %0d sel %0d",
                     $time, out_wr_addr, out_sel, ma, mb);
          end
        end
      end
    end
  end

  task automatic push_run();
    for (int t = 0; t < TILES; t++) begin
      for (int k = 0; k < IN_DIM; k++) begin
        exp_w.push_back(t * IN_DIM + k);
        exp_k.push_back(k);
      end
      for (int j = 0; j < ARRAY_N; j++) begin
        exp_o.push_back(t * ARRAY_N + j);
        exp_j.push_back(j);
      end
    end
    busy_cnt = 0;
    clr_cnt = 0;
    en_cnt = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
  endtask

  // waits for done counting cycles since CLEAR (cycle 1); optionally re-pulses start at cycle poke
  task automatic wait_done(input int poke);
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
      start = (n == poke);
    end
    start = 1'b0;
  endtask

  task automatic check_run(input string name);
    checks++;
    if (n != RUN + 1) begin errors++; $display("FAIL %s_done_cycle: got %0d want %0d", name, n, RUN + 1); end
    checks++;
    if (busy_cnt != RUN) begin errors++; $display("FAIL %s_busy_len: got %0d want %0d", name, busy_cnt, RUN); end
    checks++;
    if (clr_cnt != TILES) begin errors++; $display("FAIL %s_clr_cnt: got %0d want %0d", name, clr_cnt, TILES); end
    checks++;
    if (en_cnt != TILES * IN_DIM) begin errors++; $display("FAIL %s_acc_en_cnt: got %0d want %0d", name, en_cnt, TILES * IN_DIM); end
    checks++;
    if (exp_w.size() != 0 || exp_o.size() != 0) begin
      errors++;
      $display("FAIL %s_sb_left: got %0d reads %0d writes pending want 0 0", name, exp_w.size(), exp_o.size());
    end
    checks++;
    if (cycle_count !== EXP_CC) begin errors++; $display("FAIL %s_cycle_count: got %0d want %0d", name, cycle_count, EXP_CC); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_hold: got %h want 0", all_out); end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (all_out !== '0) begin errors++; $display("FAIL reset_idle[%0d]: got %h want 0", i, all_out); end
    end
  endtask

  task automatic test_nominal();
    push_run();
    pulse_start();
    checks++;
    if (busy !== 1'b1 || acc_clr !== 1'b1) begin
      errors++;
      $display("FAIL nominal_clear: got busy %b acc_clr %b want 1 1", busy, acc_clr);
    end
    wait_done(0);
    check_run("nominal");
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL nominal_done_hold: got done %b busy %b want 1 0", done, busy); end
  endtask

  task automatic test_start_while_busy();
    push_run();
    pulse_start();
    wait_done(3);
    check_run("busy_start");
  endtask

  task automatic test_start_at_done();
    push_run();
    pulse_start();
    wait_done(RUN);
    check_run("done_edge_start");
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || cycle_count !== EXP_CC) begin
      errors++;
      $display("FAIL done_edge_ignored: got done %b busy %b cc %0d want 1 0 %0d", done, busy, cycle_count, EXP_CC);
    end
  endtask

  task automatic test_restart();
    push_run();
    pulse_start();
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || cycle_count !== 32'd0) begin
      errors++;
      $display("FAIL restart_drop: got done %b busy %b cc %0d want 0 1 0", done, busy, cycle_count);
    end
    wait_done(0);
    check_run("restart");
  endtask

  task automatic test_reset_midrun();
    push_run();
    pulse_start();
    while (!(out_wr_en === 1'b1 && out_wr_addr === 2'd2) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL midrun_reach: got timeout want tile-1 write"); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL midrun_async_clear: got %h want 0", all_out); end
    exp_w.delete();
    exp_k.delete();
    exp_o.delete();
    exp_j.delete();
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (all_out !== '0) begin errors++; $display("FAIL midrun_in_reset: got %h want 0", all_out); end
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL midrun_after_release: got %h want 0", all_out); end
    push_run();
    pulse_start();
    wait_done(0);
    check_run("after_reset");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_start_while_busy();
    test_start_at_done();
    test_restart();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule
